// File: rtl/bsg_front_side_bus_hop_out.sv
`default_nettype none
// ============================================================================
// bsg_front_side_bus_hop_out : round-robin 2:1 merge onto an FSB link via a 2-entry FIFO
// Revision: 1.0
// ============================================================================
module bsg_front_side_bus_hop_out #(
   parameter int WIDTH_P = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [1:0]           v_i,
   input  logic [2*WIDTH_P-1:0] data_i,
   output logic [1:0]           ready_o,
   output logic                 v_o,
   output logic [WIDTH_P-1:0]   data_o,
   input  logic                 ready_i
);

   logic [WIDTH_P-1:0] mem [2];
   logic               head_r;
   logic               tail_r;
   logic               empty_r;
   logic               full_r;
   logic               last_grant_r;

   logic [1:0]         grant;
   logic               enq;
   logic               deq;
   logic               sel;
   logic [WIDTH_P-1:0] sel_word;

   // On contention the input that did not win last time gets the slot.
   always_comb begin
      grant    = 2'b00;
      grant[0] = v_i[0] & (~v_i[1] | last_grant_r);
      grant[1] = v_i[1] & (~v_i[0] | ~last_grant_r);
   end

   assign ready_o  = grant & {2{~full_r & ~reset_i}};
   assign enq      = |(v_i & ready_o);
   assign sel      = ready_o[1];
   assign sel_word = sel ? data_i[WIDTH_P +: WIDTH_P] : data_i[0 +: WIDTH_P];

   assign v_o    = ~empty_r;
   assign deq    = v_o & ready_i;
   assign data_o = mem[head_r];

   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem[tail_r] <= sel_word;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         head_r       <= 1'b0;
         tail_r       <= 1'b0;
         empty_r      <= 1'b1;
         full_r       <= 1'b0;
         last_grant_r <= 1'b1;
      end else begin
         if (enq) begin
            tail_r       <= ~tail_r;
            last_grant_r <= sel;
         end
         if (deq) begin
            head_r <= ~head_r;
         end
         // Simultaneous enq and deq leaves occupancy unchanged.
         if (enq && !deq) begin
            empty_r <= 1'b0;
            full_r  <= ~empty_r;
         end else if (deq && !enq) begin
            full_r  <= 1'b0;
            empty_r <= ~full_r;
         end
      end
   end

endmodule
`default_nettype wire
